// File: rtl/muxn_pipe_if.sv
// Handshake and data bundle for muxn_pipe: upstream offer, registered output, status.
// master = the side driving inputs/out_ready; slave = the mux itself.
interface muxn_pipe_if #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned N     = 4,
  parameter int unsigned CNTW  = 16
);
  localparam int unsigned SELW = (N > 2) ? $clog2(N) : 1;

  logic [N*WIDTH-1:0] in_data;
  logic [SELW-1:0]    sel;
  logic               in_valid;
  logic               in_ready;
  logic               flush;
  logic [WIDTH-1:0]   out_data;
  logic [SELW-1:0]    out_sel;
  logic               out_valid;
  logic               out_ready;
  logic               sel_err;
  logic [CNTW-1:0]    xfer_cnt;

  modport master (
    output in_data, sel, in_valid, flush, out_ready,
    input  in_ready, out_data, out_sel, out_valid, sel_err, xfer_cnt
  );

  modport slave (
    input  in_data, sel, in_valid, flush, out_ready,
    output in_ready, out_data, out_sel, out_valid, sel_err, xfer_cnt
  );
endinterface

// File: rtl/muxn_pipe.sv
// N:1 WIDTH-bit mux with a registered output stage, valid/ready handshake,
// flush, sticky out-of-range select flag and completed-transfer counter.
module muxn_pipe #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned N     = 4,
  parameter int unsigned CNTW  = 16
) (
  input logic        clk,
  input logic        reset,
  muxn_pipe_if.slave bus
);
  localparam int unsigned SELW = (N > 2) ? $clog2(N) : 1;

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SELW-1:0]  out_sel_q, out_sel_d;
  logic             out_valid_q, out_valid_d;
  logic             sel_err_q, sel_err_d;
  logic [CNTW-1:0]  xfer_cnt_q, xfer_cnt_d;

  logic             in_ready_c;
  logic             accept_c;
  logic             xfer_c;
  logic             sel_oob_c;
  logic [WIDTH-1:0] mux_c;

  // Constant-index lane select: unselected lanes never reach mux_c.
  always_comb begin
    mux_c = '0;
    for (int k = 0; k < int'(N); k++) begin
      if (bus.sel == SELW'(k)) mux_c = bus.in_data[k*WIDTH +: WIDTH];
    end
    sel_oob_c = 32'(bus.sel) >= N;
  end

  always_comb begin
    in_ready_c  = !reset && !bus.flush && (!out_valid_q || bus.out_ready);
    accept_c    = bus.in_valid && in_ready_c;
    xfer_c      = out_valid_q && bus.out_ready && !bus.flush;

    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_valid_d = out_valid_q;
    sel_err_d   = sel_err_q;
    xfer_cnt_d  = xfer_cnt_q;

    if (bus.flush) begin
      out_valid_d = 1'b0;
    end else begin
      if (xfer_c) begin
        out_valid_d = 1'b0;
        xfer_cnt_d  = xfer_cnt_q + CNTW'(1);
      end
      // An accept in the same cycle as a transfer replaces the departing item.
      if (accept_c) begin
        out_data_d  = mux_c;
        out_sel_d   = bus.sel;
        out_valid_d = 1'b1;
        if (sel_oob_c) sel_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_valid_q <= 1'b0;
      sel_err_q   <= 1'b0;
      xfer_cnt_q  <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_valid_q <= out_valid_d;
      sel_err_q   <= sel_err_d;
      xfer_cnt_q  <= xfer_cnt_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sel_err   = sel_err_q;
  assign bus.xfer_cnt  = xfer_cnt_q;
endmodule
